// File: rtl/mem_sched_pkg.sv
// Shared types and limits for the memory access scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_sched_pkg;

    // Scheduler control states; one BRAM access in flight at most
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } mem_sched_state_t;

    // Requester identity used for grant, ack routing and rdata steering
    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } req_id_t;

    // Largest BRAM read latency the 3-bit wait counter can cover
    localparam int RD_LAT_MAX = 7;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-input round-robin arbiter (CPU vs loader) with a last-grant register.
// Latency: grant is combinational from the requests; last-grant updates on the enabled edge.
// Backpressure: i_en gates when a grant is taken; requests are simply held until granted.
module mem_rr_arb2
    import mem_sched_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_en,
    input  logic    i_req_cpu,
    input  logic    i_req_ldr,
    output logic    o_gnt_vld,
    output req_id_t o_gnt_id
);

    req_id_t r_last_grant;

    // On a tie the requester that was not granted last wins
    always_comb begin
        o_gnt_vld = i_req_cpu | i_req_ldr;
        o_gnt_id  = CPU;
        if (i_req_cpu && i_req_ldr) begin
            if (r_last_grant == CPU) begin
                o_gnt_id = LDR;
            end else begin
                o_gnt_id = CPU;
            end
        end else if (i_req_ldr) begin
            o_gnt_id = LDR;
        end
    end

    // Remember the winner of every taken grant; LDR at reset so CPU wins the first tie
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= LDR;
        end else if (i_en && o_gnt_vld) begin
            r_last_grant <= o_gnt_id;
        end
    end

endmodule

// File: rtl/mem_access_sched.sv
// Serialises CPU / loader requests onto a single-port synchronous BRAM (optional loader: MEM_SCHED_LOADER_EN).
// Latency: write ack 2 cycles after req is seen in IDLE, read ack 2+RD_LAT cycles; all outputs registered.
// Backpressure: requesters hold req/we/addr/wdata until their one-cycle ack; inputs sampled only in IDLE.
module mem_access_sched
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_access_sched: RD_LAT must be within 1..7");
    end

    // WAIT lasts RD_LAT-1 cycles; counter is loaded with 1 on entry
    localparam logic [2:0] LP_CNT_LAST = 3'(RD_LAT - 1);

    mem_sched_state_t  r_state;
    logic [2:0]        r_cnt;
    req_id_t           r_id;
    logic              r_we;
    logic              r_cpu_ack;
    logic              r_ldr_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic              r_bram_ena;
    logic              r_bram_wea;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [DATA_W-1:0] r_bram_din;
    logic              r_busy;

    logic              w_gnt_vld;
    req_id_t           w_gnt_id;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

`ifdef MEM_SCHED_LOADER_EN
    mem_rr_arb2 u_arb (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_en      (r_state == IDLE),
        .i_req_cpu (cpu_req),
        .i_req_ldr (ldr_req),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    // Steer the winning port's request fields into the latch path
    always_comb begin
        w_we    = cpu_we;
        w_addr  = cpu_addr;
        w_wdata = cpu_wdata;
        if (w_gnt_id == LDR) begin
            w_we    = ldr_we;
            w_addr  = ldr_addr;
            w_wdata = ldr_wdata;
        end
    end

    assign ldr_ack   = r_ldr_ack;
    assign ldr_rdata = r_ldr_rdata;
`else
    // Without the loader the CPU is the only requester and always wins
    assign w_gnt_vld = cpu_req;
    assign w_gnt_id  = CPU;
    assign w_we      = cpu_we;
    assign w_addr    = cpu_addr;
    assign w_wdata   = cpu_wdata;
    assign ldr_ack   = 1'b0;
    assign ldr_rdata = '0;

    logic w_unused_ldr;
    assign w_unused_ldr = ^{ldr_req, ldr_we, ldr_addr, ldr_wdata, r_ldr_ack, r_ldr_rdata};
`endif

    // Control FSM: latch winner in IDLE, one-cycle BRAM access, wait out read latency, ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_id        <= CPU;
            r_we        <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ldr_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_bram_ena  <= 1'b0;
            r_bram_wea  <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_cpu_ack  <= 1'b0;
            r_ldr_ack  <= 1'b0;
            r_bram_ena <= 1'b0;
            r_bram_wea <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        // bram_addr/bram_din double as the address/data latches
                        r_id        <= w_gnt_id;
                        r_we        <= w_we;
                        r_bram_ena  <= 1'b1;
                        r_bram_wea  <= w_we;
                        r_bram_addr <= w_addr;
                        r_bram_din  <= w_wdata;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        if (r_id == CPU) begin
                            r_cpu_ack <= 1'b1;
                        end else begin
                            r_ldr_ack <= 1'b1;
                        end
                        r_state <= DONE;
                    end else if (RD_LAT == 1) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_cnt   <= 3'd1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == LP_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                CAPTURE: begin
                    // Ack is raised together with the data so rdata is valid during ack
                    if (r_id == CPU) begin
                        r_cpu_rdata <= bram_dout;
                        r_cpu_ack   <= 1'b1;
                    end else begin
                        r_ldr_rdata <= bram_dout;
                        r_ldr_ack   <= 1'b1;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign bram_ena  = r_bram_ena;
    assign bram_wea  = r_bram_wea;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_access_sched.sv
// Scoreboard bench for mem_access_sched with a behavioural BRAM (RD_LAT-deep read pipe).
// Latency: requests are stamped with the cycle they are raised; acks are checked against that.
// Backpressure: each port holds its request until ack, then drops it the following cycle.
module tb_mem_access_sched;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, ldr_req, ldr_we;
    logic [ADDR_W-1:0] cpu_addr, ldr_addr;
    logic [DATA_W-1:0] cpu_wdata, ldr_wdata;
    logic              cpu_ack, ldr_ack;
    logic [DATA_W-1:0] cpu_rdata, ldr_rdata;
    logic              bram_ena, bram_wea;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din, bram_dout;
    logic              busy;

    mem_access_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .ldr_rdata (ldr_rdata),
        .bram_ena  (bram_ena),
        .bram_wea  (bram_wea),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port BRAM: address register plus RD_LAT-1 output stages
    logic [DATA_W-1:0] bram_mem [0:65535];
    logic [DATA_W-1:0] pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (bram_ena) begin
            if (bram_wea) bram_mem[bram_addr] <= bram_din;
            pipe[0] <= bram_mem[bram_addr];
        end
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_dout = pipe[RD_LAT-1];

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          t0;
        int          lat;
    } txn_t;

    txn_t        sb[$];
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rd [2];
    int          cyc = 0;
    int          ena_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    txn_t        mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every BRAM access and every ack is matched against the scoreboard head
    always @(negedge clk) begin
        if (!reset) begin
            if (bram_ena) begin
                ena_cnt++;
                check("busy_at_issue", busy, 1);
                if (sb.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                end else begin
                    check("issue_we", bram_wea, sb[0].we);
                    check("issue_addr", bram_addr, sb[0].addr);
                    if (sb[0].we) check("issue_din", bram_din, sb[0].wdata);
                end
            end
            if (cpu_ack || ldr_ack) begin
                check("ack_both", cpu_ack & ldr_ack, 0);
                if (sb.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_port", ldr_ack ? 1 : 0, mon_e.port);
                    check("ena_pulses", ena_cnt, 1);
                    check("busy_at_ack", busy, 1);
                    if (mon_e.lat >= 0) check("ack_latency", cyc - mon_e.t0, mon_e.lat);
                    if (!mon_e.we) exp_rd[mon_e.port] = mon_e.rdata;
                    check("cpu_rdata", cpu_rdata, exp_rd[0]);
                    check("ldr_rdata", ldr_rdata, exp_rd[1]);
                end
                ena_cnt = 0;
            end
        end
    end

    // Raise a request (call at #1 after a posedge) and record its expected outcome
    task automatic start_req(input int port, input logic we, input logic [15:0] addr,
                             input logic [15:0] wd, input int lat);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wd; t.t0 = cyc; t.lat = lat;
        t.rdata = 16'h0;
        if (we) ref_mem[int'(addr)] = wd;
        else if (ref_mem.exists(int'(addr))) t.rdata = ref_mem[int'(addr)];
        sb.push_back(t);
        if (port == 0) begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        end else begin
            ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
        end
    endtask

    // Wait (bounded) for the port's ack, then drop its request in the following cycle
    task automatic wait_ack(input int port);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((port == 0 && cpu_ack) || (port == 1 && ldr_ack)) got = 1;
        end
        if (!got) check("ack_timeout", 0, 1);
        @(posedge clk); #1;
        if (port == 0) cpu_req = 1'b0; else ldr_req = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef MEM_SCHED_LOADER_EN
    task automatic tie_round(input int first, input logic [15:0] addr);
        start_req(first, 1'b1, addr, addr ^ 16'h5A5A, -1);
        start_req(1 - first, 1'b1, addr + 16'h1, addr ^ 16'hA5A5, -1);
        wait_ack(first);
        wait_ack(1 - first);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_bram_ena", bram_ena, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ldr_ack", ldr_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ldr_rdata", ldr_rdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

`ifdef MEM_SCHED_LOADER_EN
        // Tie right after reset: CPU first, then alternation
        tie_round(0, 16'h5000);
        tie_round(0, 16'h5010);
        start_req(0, 1'b1, 16'h5020, 16'h1234, 2);
        wait_ack(0);
        tie_round(1, 16'h5030);
`endif

        // Single write and read-back at default latency
        start_req(0, 1'b1, 16'h3000, 16'hBEEF, 2);
        wait_ack(0);
        start_req(0, 1'b0, 16'h3000, 16'h0, 2 + RD_LAT);
        wait_ack(0);

`ifndef MEM_SCHED_LOADER_EN
        // Loader held high must be invisible; CPU timing unchanged
        ldr_we = 1'b1; ldr_addr = 16'h3000; ldr_wdata = 16'hDEAD; ldr_req = 1'b1;
        start_req(0, 1'b0, 16'h3000, 16'h0, 2 + RD_LAT);
        wait_ack(0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (ldr_ack) n++;
        end
        check("ldr_ack_never", n, 0);
        @(posedge clk); #1;
        ldr_req = 1'b0;
`endif

        // Reset during WAIT of a read: immediate clear, no ack afterwards
        start_req(0, 1'b0, 16'h3000, 16'h0, 2 + RD_LAT);
        @(posedge clk);
        @(posedge clk); #1;
        check("busy_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ena", bram_ena, 0);
        check("rst_mid_cpu_ack", cpu_ack, 0);
        check("rst_mid_cpu_rdata", cpu_rdata, 0);
        sb.delete();
        ena_cnt = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) n++;
        end
        check("no_ack_after_reset", n, 0);
        @(posedge clk); #1;
        start_req(0, 1'b0, 16'h3000, 16'h0, 2 + RD_LAT);
        wait_ack(0);

        // Address changed one cycle after the grant must not reach the BRAM
        start_req(0, 1'b0, 16'h3000, 16'h0, 2 + RD_LAT);
        @(posedge clk); #1;
        cpu_addr = 16'h0001;
        wait_ack(0);

        // A few more write/read pairs with varied data
        for (int i = 0; i < 4; i++) begin
            start_req(0, 1'b1, 16'h4000 + 16'(i * 3), 16'($urandom), 2);
            wait_ack(0);
        end
        for (int i = 3; i >= 0; i--) begin
            start_req(0, 1'b0, 16'h4000 + 16'(i * 3), 16'h0, 2 + RD_LAT);
            wait_ack(0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_sched.md
# mem_access_sched

Memory access scheduler between the SLC-3 datapath and the single-port synchronous block RAM. Accepts read/write requests from the CPU control path and from a program-loader/debug port, grants one at a time with round-robin arbitration, and hides the BRAM read latency (address register plus output register) behind a req/ack handshake. The control FSM waits for `cpu_ack` instead of stepping through fixed wait states.

## Interface
- `ADDR_W`, 16, BRAM word-address width
- `DATA_W`, 16, data width
- `RD_LAT`, 2, BRAM read latency in cycles from enable to valid `bram_dout`; legal range 1..7
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `cpu_req`, `cpu_we`  in  1  CPU request; write when high
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  DATA_W  read data; valid while `cpu_ack` is high, held until the next CPU read
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_rdata`: loader port, same widths and meaning as the CPU port
- `bram_ena`, `bram_wea`  out  1  BRAM enable and write enable
- `bram_addr`  out  ADDR_W  BRAM address
- `bram_din`  out  DATA_W  BRAM write data
- `bram_dout`  in  DATA_W  BRAM read data
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: if any `*_req` is high, pick the winner, latch its we/addr/wdata and id, go to ISSUE.
  - ISSUE: drive `bram_ena=1`, `bram_wea=we`, `bram_addr`, `bram_din` from the latches for exactly one cycle. Writes go to DONE; reads go to WAIT, or to CAPTURE when RD_LAT=1.
  - WAIT: a 3-bit counter runs RD_LAT-1 cycles, then the FSM goes to CAPTURE.
  - CAPTURE: register `bram_dout` into the winner's rdata register, go to DONE.
  - DONE: pulse the winner's `*_ack`, return to IDLE.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester not granted last wins.
  - `last_grant` updates on every grant. Its reset value is LDR, so the CPU wins the first tie.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until its ack, and drops req in the cycle after ack.
  - Inputs are sampled only in IDLE. Changes after the grant are ignored.
  - Dropping req early does not abort the transaction; ack still pulses.
- Writes never update `*_rdata`. The rdata register of the losing port is unaffected.
- Reset: asynchronous; takes effect immediately even mid-transaction.
  - FSM goes to IDLE, counter to 0, `last_grant` to LDR.
  - All outputs go to 0: `bram_*`, acks, rdata, `busy`.
  - An in-flight transaction is dropped without an ack.

## Timing
- Request first seen high in IDLE at cycle R. ISSUE at R+1.
- Write: BRAM write at R+1, ack at R+2.
- Read: capture at R+1+RD_LAT, ack at R+2+RD_LAT (R+4 at default).
- Back-to-back: the cycle after DONE is IDLE, so the next ISSUE is at the earliest 3 cycles after the previous ack's ISSUE+latency. No overlap of BRAM accesses.
- Acks are registered outputs. No combinational path from req to ack or to `bram_*`.

## Configuration
- `MEM_SCHED_LOADER_EN` defined: loader port and round-robin arbitration are present.
- Not defined:
  - Loader inputs are ignored; `ldr_ack` and `ldr_rdata` are tied to 0.
  - The CPU is always the winner and `last_grant` logic is removed.
  - CPU timing is unchanged.

## Structure
- Package `mem_sched_pkg` holds:
  - `mem_sched_state_t` enum: IDLE, ISSUE, WAIT, CAPTURE, DONE.
  - `req_id_t` enum: CPU, LDR.
  - The RD_LAT upper-limit constant.
- Sub-module `mem_rr_arb2`: a two-input round-robin arbiter with the `last_grant` register and a grant-enable input. It is instantiated only under `MEM_SCHED_LOADER_EN`.

## Test plan
- Reset, then CPU write 0x3000 ← 0xBEEF: `bram_ena`=`bram_wea`=1 for exactly one cycle with addr 0x3000 and data 0xBEEF; `cpu_ack` 2 cycles after req.
- CPU read 0x3000 with a BRAM model at RD_LAT=2: `cpu_ack` 4 cycles after req; `cpu_rdata`=0xBEEF during ack; `ldr_rdata` unchanged.
- CPU and loader req in the same cycle after reset: CPU served first. Both held again: loader served next. Alternation continues over 4 transactions.
- `reset` asserted in the WAIT state of a read: `bram_ena`, acks and `busy` go to 0 immediately; no ack after release; a new CPU read completes correctly.
- `cpu_addr` changed to 0x0001 one cycle after the grant: the BRAM still sees the originally latched 0x3000.
- Build without `MEM_SCHED_LOADER_EN`, `ldr_req` held high: `ldr_ack` never asserts; CPU read latency is still 4 cycles.
